// File: rtl/rr_pipe_pkg.sv
// Shared definitions for the round-robin register-pipeline arbiter family.
//   N_REQ_DEF / WIDTH_DEF : default requester count and data width
//   id_width()            : width of a requester tag for a given requester count
//   RESET_FILL/RESET_DATA : data registers reset to all ones
package rr_pipe_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;

  // Fill bit for data registers at reset; wider words replicate it.
  localparam logic                 RESET_FILL = 1'b1;
  localparam logic [WIDTH_DEF-1:0] RESET_DATA = {WIDTH_DEF{RESET_FILL}};

  // Tag width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req : per-requester request bits
//   ptr : highest-priority index for this cycle (must be < N_REQ)
//   en  : when low, nothing is granted
//   gnt : one-hot grant (all zero when en=0 or req=0)
//   idx : binary index of the granted requester (0 when no grant)
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx
);

  int   cand;
  logic found;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    // Scan ptr, ptr+1, ... wrapping at N_REQ; first set request wins.
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (en && !found && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = ID_W'(cand);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_reg_pipe_arbiter.sv
// Round-robin arbiter feeding a shared two-stage register pipeline
// (capture stage s0, then output stage dout) with a valid/ready output.
//   clk        : clock, all state on posedge
//   reset      : synchronous active-low reset
//   req        : per-requester request, held until granted
//   din        : requester data, slice i = din[i*WIDTH +: WIDTH]
//   gnt        : one-hot combinational grant; word captured at that posedge
//   dout       : output-stage data
//   dout_id    : requester index of dout
//   dout_valid : output stage holds a valid word
//   dout_ready : downstream accepts dout
module rr_reg_pipe_arbiter
  import rr_pipe_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  localparam int ID_W  = id_width(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] din,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       dout,
  output logic [ID_W-1:0]        dout_id,
  output logic                   dout_valid,
  input  logic                   dout_ready
);

  logic             adv;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  ptr_next;
  logic [ID_W-1:0]  pick_idx;
  logic [WIDTH-1:0] pick_data;
  logic [WIDTH-1:0] s0_data;
  logic [ID_W-1:0]  s0_id;
  logic             s0_v;

  // One global enable: both stages shift together or both hold.
  assign adv = !dout_valid || dout_ready;

  // Grants are suppressed during reset as well as during a stall.
  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .en  (adv && reset),
    .gnt (gnt),
    .idx (pick_idx)
  );

  assign ptr_next  = (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
  assign pick_data = din[int'(pick_idx)*WIDTH +: WIDTH];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: data and tag registers are reset too (to a known all-ones pattern), not just the valid bits.
      ptr        <= '0;
      s0_v       <= 1'b0;
      s0_data    <= {WIDTH{RESET_FILL}};
      s0_id      <= '0;
      dout_valid <= 1'b0;
      dout       <= {WIDTH{RESET_FILL}};
      dout_id    <= '0;
    end else if (adv) begin
      if (|gnt) ptr <= ptr_next;
      // Bubbles are not squeezed: data/id load even when no grant.
      s0_data    <= pick_data;
      s0_id      <= pick_idx;
      s0_v       <= |gnt;
      dout       <= s0_data;
      dout_id    <= s0_id;
      dout_valid <= s0_v;
    end
  end

endmodule

// File: tb/tb_rr_reg_pipe_arbiter.sv
// Directed self-checking bench for rr_reg_pipe_arbiter (N_REQ=4, WIDTH=8).
module tb_rr_reg_pipe_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  gnt;
  logic [7:0]  dout;
  logic [1:0]  dout_id;
  logic        dout_valid;
  logic        dout_ready;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [31:0] DIN_BASE = 32'hD3C2_B1A0;  // slice i = A0 + 11*i

  rr_reg_pipe_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .din        (din),
    .gnt        (gnt),
    .dout       (dout),
    .dout_id    (dout_id),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] id);
    check({tag, "_valid"}, 32'(dout_valid), 32'(v));
    check({tag, "_data"},  32'(dout),       32'(d));
    check({tag, "_id"},    32'(dout_id),    32'(id));
  endtask

  task automatic check_gnt(input string tag, input logic [3:0] exp);
    check(tag, 32'(gnt), 32'(exp));
  endtask

  // Advance one edge, then step clear of it before driving/sampling.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    req        = 4'b1111;
    din        = DIN_BASE;
    dout_ready = 1'b1;

    // Reset held for two edges with all requests up.
    cycle(); settle();
    check_gnt("rst1_gnt", 4'b0000);
    check_out("rst1", 1'b0, 8'hFF, 2'd0);
    cycle(); settle();
    check_gnt("rst2_gnt", 4'b0000);
    check_out("rst2", 1'b0, 8'hFF, 2'd0);

    // Release: first grant goes to requester 0.
    reset = 1'b1; settle();
    check_gnt("first_gnt", 4'b0001);
    cycle();                       // A0/id0 captured, ptr=1
    req = 4'b0100; din = 32'hD35A_B1A0; settle();
    check_gnt("single_gnt", 4'b0100);
    check("lat_not_yet", 32'(dout_valid), 32'd0);
    cycle();                       // dout=A0/0, s0=5A/2, ptr=3
    req = 4'b0000; settle();
    check_gnt("idle_gnt", 4'b0000);
    check_out("w0", 1'b1, 8'hA0, 2'd0);
    cycle();                       // dout=5A/2
    settle();
    check_out("single", 1'b1, 8'h5A, 2'd2);
    din = DIN_BASE;
    req = 4'b1001; settle();
    check_gnt("prio_from_3", 4'b1000);
    cycle();                       // s0=D3/3, ptr wraps to 0
    settle();
    check("bubble_valid", 32'(dout_valid), 32'd0);
    check_gnt("wrap_gnt", 4'b0001);
    cycle();                       // dout=D3/3, s0=A0/0, ptr=1
    req = 4'b1000; settle();
    check_out("wrap_w3", 1'b1, 8'hD3, 2'd3);
    check_gnt("only3", 4'b1000);
    cycle();                       // dout=A0/0, s0=D3/3, ptr=0
    settle();
    check_out("wrap_w0", 1'b1, 8'hA0, 2'd0);
    check_gnt("only3_again", 4'b1000);
    cycle();                       // dout=D3/3, s0=D3/3
    req = 4'b0000; settle();
    check_out("only3_w1", 1'b1, 8'hD3, 2'd3);
    cycle();
    settle();
    check_out("only3_w2", 1'b1, 8'hD3, 2'd3);
    cycle();
    settle();
    check("drain_valid", 32'(dout_valid), 32'd0);

    // Full load, ready high: one word per cycle in rotating order.
    req = 4'b1111; settle();
    for (int k = 0; k < 7; k++) begin
      check_gnt($sformatf("rr_gnt%0d", k), 4'b0001 << (k % 4));
      if (k >= 2)
        check_out($sformatf("rr_out%0d", k), 1'b1,
                  8'hA0 + 8'h11 * 8'((k - 2) % 4), 2'((k - 2) % 4));
      cycle(); settle();
    end
    // Now dout=id1/B1, s0=id2/C2, ptr=3.

    // Stall three cycles with both stages full.
    dout_ready = 1'b0; settle();
    for (int k = 0; k < 3; k++) begin
      check_gnt($sformatf("stall_gnt%0d", k), 4'b0000);
      check_out($sformatf("stall%0d", k), 1'b1, 8'hB1, 2'd1);
      cycle(); settle();
    end
    dout_ready = 1'b1; settle();
    check_gnt("ptr_held", 4'b1000);
    cycle();                       // dout=C2/2, s0=D3/3, ptr=0
    req = 4'b0000; settle();
    check_out("post_stall_a", 1'b1, 8'hC2, 2'd2);
    cycle();
    settle();
    check_out("post_stall_b", 1'b1, 8'hD3, 2'd3);
    cycle();
    settle();
    check("post_stall_end", 32'(dout_valid), 32'd0);

    // Reset with two words in flight.
    req = 4'b1111; settle();
    cycle();                       // s0=A0/0, ptr=1
    cycle();                       // dout=A0/0, s0=B1/1, ptr=2
    reset = 1'b0; settle();
    check_gnt("rst_mask_gnt", 4'b0000);
    cycle();
    reset = 1'b1; req = 4'b0000; settle();
    check_out("inflight_rst", 1'b0, 8'hFF, 2'd0);
    cycle(); settle();
    check("drop1_valid", 32'(dout_valid), 32'd0);
    cycle(); settle();
    check("drop2_valid", 32'(dout_valid), 32'd0);
    req = 4'b0110; settle();
    check_gnt("ptr_after_rst", 4'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
